router_fsm_nch: RTL and testbench
=================================

// Module: router_fsm_nch
// PURPOSE
//  Control FSM of the 1xN packet router, generalising the 1x3 controller to NUM_CH output channels.
//  Decodes the header address, sequences header/payload/parity writes into the selected channel FIFO,
//  and stalls the source while that FIFO is full or not yet empty.
//  New in this generation:
//   - out-of-range addresses are dropped, not written;
//   - WAIT_TILL_EMPTY has a configurable timeout;
//   - the latched channel is exported one-hot to the synchroniser/FIFO muxes.
// PARAMETERS
//  NUM_CH        3    number of output channels/FIFOs, 2..16
//  ADDR_W        2    header address field width, data_in[ADDR_W-1:0]; 2**ADDR_W >= NUM_CH
//  WAIT_TIMEOUT  256  cycles allowed in WAIT_TILL_EMPTY before drop; 0 = wait forever
// PORTS
//  clock          in   1        rising-edge clock
//  resetn         in   1        asynchronous active-low reset
//  pkt_valid      in   1        source packet valid; low on the parity byte
//  data_in        in   ADDR_W   header address bits of the input byte
//  fifo_empty     in   NUM_CH   per-channel FIFO empty
//  fifo_full      in   1        full flag of the currently selected FIFO
//  soft_reset     in   NUM_CH   per-channel soft reset (read-timeout) from synchroniser
//  parity_done    in   1        register block: parity byte captured
//  low_pkt_valid  in   1        register block: pkt_valid fell while FIFO was full
//  detect_add     out  1        state == DECODE_ADDRESS
//  lfd_state      out  1        state == LOAD_FIRST_DATA
//  ld_state       out  1        state == LOAD_DATA
//  laf_state      out  1        state == LOAD_AFTER_FULL
//  full_state     out  1        state == FIFO_FULL_STATE
//  write_enb_reg  out  1        LFD | LD | LAF | LOAD_PARITY
//  rst_int_reg    out  1        state == CHECK_PARITY_ERROR
//  busy           out  1        LFD | FFS | LAF | LP | CPE | WAIT_TILL_EMPTY
//  drop_state     out  1        state == DROP_PACKET
//  drop_err       out  1        1-cycle pulse on every entry to DROP_PACKET (registered)
//  sel_ch         out  NUM_CH   one-hot latched channel; 0 when none or invalid
// BEHAVIOUR
//  Reset (async, resetn=0):
//   - state=DECODE_ADDRESS, addr_q=0, sel_ch=0, wait_cnt=0, drop_err=0.
//   - Hence detect_add=1 and every other output is 0.
//  Address latch:
//   - in DECODE_ADDRESS with pkt_valid=1: addr_q<=data_in.
//   - sel_ch<=onehot(data_in) if data_in<NUM_CH, else 0.
//   - addr_q and sel_ch hold until the next DECODE_ADDRESS.
//  Transitions (4-bit encoded state, all registered, a = data_in):
//   - DECODE: pkt_valid & a<NUM_CH & fifo_empty[a] -> LFD.
//     pkt_valid & a<NUM_CH & !fifo_empty[a] -> WAIT. pkt_valid & a>=NUM_CH -> DROP. Else stay.
//   - LFD -> LD.
//   - LD: fifo_full -> FFS; else !pkt_valid -> LP; else stay.
//   - FFS: !fifo_full -> LAF; else stay.
//   - LAF: parity_done -> DECODE; else low_pkt_valid -> LP; else LD.
//   - LP -> CPE.
//   - CPE: fifo_full -> FFS; else DECODE.
//   - WAIT: fifo_empty[addr_q] -> LFD.
//     Else if WAIT_TIMEOUT!=0 & wait_cnt==WAIT_TIMEOUT-1 -> DROP. Else stay.
//     Uses the latched channel only, never another channel's flag.
//   - DROP: busy=0 and write_enb_reg=0, so the source streams and bytes are discarded.
//     The first cycle with pkt_valid=0 (parity byte) -> DECODE.
//  wait_cnt: cleared in every state except WAIT; increments in WAIT and saturates.
//  Soft reset: soft_reset[addr_q]=1 while state!=DECODE forces the next state to DECODE.
//   - sel_ch<=0 and wait_cnt<=0; this overrides all transitions.
//   - soft_reset of other channels is ignored.
//  Simultaneous events:
//   - In LD, fifo_full with pkt_valid=0 -> FFS (full wins).
//   - In WAIT, the empty check wins over the timeout on the same cycle.
//  Outputs are pure decodes of the state register, except sel_ch and drop_err, which are registered.
// STRUCTURE
//  Package router_pkg: state enum/localparams; onehot helper function; shared by sync/register blocks.
//  No sub-module: a single always_ff for state/addr_q/sel_ch/wait_cnt, one always_comb for next state.
// TESTING
//  - Reset: resetn=0 mid-LD -> next edge state=DECODE, detect_add=1, busy=0, sel_ch=0.
//  - NUM_CH=4: header a=3, fifo_empty=4'b1000, 4-byte packet -> LFD,LD x4,LP,CPE.
//    write_enb_reg high for 6 cycles; sel_ch=4'b1000.
//  - a=2, fifo_empty[2]=0 held 10 cycles, fifo_empty[0]=1 -> WAIT for 10 cycles,
//    busy=1, no exit via channel 0; then empty[2]=1 -> LFD.
//  - WAIT_TIMEOUT=8, fifo_empty[1]=0 forever -> DROP after exactly 8 WAIT cycles,
//    drop_err pulses once, DECODE after the parity byte.
//  - NUM_CH=3, header a=3 -> DROP, write_enb_reg=0 throughout, busy=0, back to DECODE.
//  - fifo_full in LD -> FFS; release -> LAF; low_pkt_valid=1 -> LP.
//    soft_reset[addr_q] asserted in FFS -> DECODE next edge.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and helpers for the 1xN router control path.
// Used by the FSM and by the synchroniser/register blocks.
package router_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic [3:0] {
        DECODE_ADDRESS     = 4'd0,
        LOAD_FIRST_DATA    = 4'd1,
        LOAD_DATA          = 4'd2,
        FIFO_FULL_STATE    = 4'd3,
        LOAD_AFTER_FULL    = 4'd4,
        LOAD_PARITY        = 4'd5,
        CHECK_PARITY_ERROR = 4'd6,
        WAIT_TILL_EMPTY    = 4'd7,
        DROP_PACKET        = 4'd8
    } state_t;

    // All-zero result when idx is not a valid channel.
    function automatic logic [MAX_CH-1:0] onehot(
        input int unsigned idx,
        input int unsigned n
    );
        logic [MAX_CH-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (i < n && idx == i) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/router_fsm_nch.sv
// Control FSM of the 1xN packet router: header decode, FIFO write
// sequencing, stall while the selected FIFO is full or still draining.
module router_fsm_nch
    import router_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 256
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] soft_reset,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy,
    output logic              drop_state,
    output logic              drop_err,
    output logic [NUM_CH-1:0] sel_ch
);

    localparam int CW =
        (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TIMEOUT - 1);

    state_t            state;
    state_t            nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [CW-1:0]     wait_cnt;
    logic [NUM_CH-1:0] oh_in;
    logic [NUM_CH-1:0] oh_q;
    logic              addr_ok;
    logic              empty_in;
    logic              empty_q;
    logic              soft_hit;
    logic              timeout_hit;

    assign oh_in = NUM_CH'(onehot(32'(data_in), NUM_CH));
    assign oh_q  = NUM_CH'(onehot(32'(addr_q), NUM_CH));

    assign addr_ok  = |oh_in;
    assign empty_in = |(fifo_empty & oh_in);
    // WAIT only ever looks at the channel latched with the header.
    assign empty_q  = |(fifo_empty & oh_q);

    assign soft_hit =
        (state != DECODE_ADDRESS) && (|(soft_reset & oh_q));

    assign timeout_hit =
        (WAIT_TIMEOUT != 0) && (wait_cnt == CNT_LAST);

    always_comb begin
        nxt = state;
        unique case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (!addr_ok) begin
                        nxt = DROP_PACKET;
                    end else if (empty_in) begin
                        nxt = LOAD_FIRST_DATA;
                    end else begin
                        nxt = WAIT_TILL_EMPTY;
                    end
                end
            end
            LOAD_FIRST_DATA: nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full) begin
                    nxt = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    nxt = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    nxt = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    nxt = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    nxt = LOAD_PARITY;
                end else begin
                    nxt = LOAD_DATA;
                end
            end
            LOAD_PARITY: nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                if (fifo_full) begin
                    nxt = FIFO_FULL_STATE;
                end else begin
                    nxt = DECODE_ADDRESS;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (empty_q) begin
                    nxt = LOAD_FIRST_DATA;
                end else if (timeout_hit) begin
                    nxt = DROP_PACKET;
                end
            end
            DROP_PACKET: begin
                if (!pkt_valid) begin
                    nxt = DECODE_ADDRESS;
                end
            end
            default: nxt = DECODE_ADDRESS;
        endcase
        if (soft_hit) begin
            nxt = DECODE_ADDRESS;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= DECODE_ADDRESS;
            addr_q   <= '0;
            sel_ch   <= '0;
            wait_cnt <= '0;
            drop_err <= 1'b0;
        end else begin
            state    <= nxt;
            drop_err <= (nxt == DROP_PACKET) &&
                        (state != DROP_PACKET);
            if (soft_hit) begin
                sel_ch <= '0;
            end else if (state == DECODE_ADDRESS && pkt_valid) begin
                addr_q <= data_in;
                sel_ch <= oh_in;
            end
            if (soft_hit || state != WAIT_TILL_EMPTY) begin
                wait_cnt <= '0;
            end else if (wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign detect_add    = (state == DECODE_ADDRESS);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign drop_state    = (state == DROP_PACKET);

    assign write_enb_reg = lfd_state | ld_state | laf_state |
                           (state == LOAD_PARITY);

    assign busy = lfd_state | full_state | laf_state |
                  (state == LOAD_PARITY) | rst_int_reg |
                  (state == WAIT_TILL_EMPTY);

endmodule

// File: tb/tb_router_fsm_nch.sv
// Random-stimulus bench for router_fsm_nch (4 channels, 3-bit address,
// timeout 8) against a rule-level reference model.
module tb_router_fsm_nch;

    localparam int NCH = 4;
    localparam int AW  = 3;
    localparam int TO  = 8;

    localparam int M_DEC  = 10;
    localparam int M_LFD  = 11;
    localparam int M_LD   = 12;
    localparam int M_FFS  = 13;
    localparam int M_LAF  = 14;
    localparam int M_LP   = 15;
    localparam int M_CPE  = 16;
    localparam int M_WAIT = 17;
    localparam int M_DROP = 18;

    logic           clock = 1'b0;
    logic           resetn;
    logic           pkt_valid;
    logic [AW-1:0]  data_in;
    logic [NCH-1:0] fifo_empty;
    logic           fifo_full;
    logic [NCH-1:0] soft_reset;
    logic           parity_done;
    logic           low_pkt_valid;
    logic           detect_add;
    logic           lfd_state;
    logic           ld_state;
    logic           laf_state;
    logic           full_state;
    logic           write_enb_reg;
    logic           rst_int_reg;
    logic           busy;
    logic           drop_state;
    logic           drop_err;
    logic [NCH-1:0] sel_ch;

    int n_vec = 0;
    int n_err = 0;
    int we_seen = 0;

    int             m_mode;
    int             m_addr;
    int             m_cnt;
    logic [NCH-1:0] m_sel;
    logic           m_derr;

    router_fsm_nch #(
        .NUM_CH      (NCH),
        .ADDR_W      (AW),
        .WAIT_TIMEOUT(TO)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .soft_reset   (soft_reset),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .write_enb_reg(write_enb_reg),
        .rst_int_reg  (rst_int_reg),
        .busy         (busy),
        .drop_state   (drop_state),
        .drop_err     (drop_err),
        .sel_ch       (sel_ch)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     tag, $time, got, exp);
        end
    endtask

    // {detect, lfd, ld, laf, full, wr_en, rst_int, busy, drop}
    function automatic logic [8:0] exp_bits(input int m);
        logic [8:0] b;
        b[8] = (m == M_DEC);
        b[7] = (m == M_LFD);
        b[6] = (m == M_LD);
        b[5] = (m == M_LAF);
        b[4] = (m == M_FFS);
        b[3] = (m inside {M_LFD, M_LD, M_LAF, M_LP});
        b[2] = (m == M_CPE);
        b[1] = (m inside {M_LFD, M_FFS, M_LAF, M_LP, M_CPE, M_WAIT});
        b[0] = (m == M_DROP);
        return b;
    endfunction

    task automatic model_reset();
        m_mode = M_DEC;
        m_addr = 0;
        m_cnt  = 0;
        m_sel  = '0;
        m_derr = 1'b0;
    endtask

    task automatic model_step();
        int a;
        int nx;
        a  = int'(data_in);
        nx = m_mode;
        case (m_mode)
            M_DEC:
                if (pkt_valid)
                    nx = (a >= NCH) ? M_DROP :
                         (fifo_empty[a] ? M_LFD : M_WAIT);
            M_LFD: nx = M_LD;
            M_LD:
                nx = fifo_full ? M_FFS : (!pkt_valid ? M_LP : M_LD);
            M_FFS: nx = fifo_full ? M_FFS : M_LAF;
            M_LAF:
                nx = parity_done ? M_DEC :
                     (low_pkt_valid ? M_LP : M_LD);
            M_LP:  nx = M_CPE;
            M_CPE: nx = fifo_full ? M_FFS : M_DEC;
            M_WAIT:
                nx = fifo_empty[m_addr] ? M_LFD :
                     ((m_cnt == TO - 1) ? M_DROP : M_WAIT);
            M_DROP: nx = pkt_valid ? M_DROP : M_DEC;
            default: nx = M_DEC;
        endcase
        if (m_mode != M_DEC && m_addr < NCH && soft_reset[m_addr]) begin
            nx    = M_DEC;
            m_sel = '0;
            m_cnt = 0;
        end else begin
            m_cnt = (m_mode == M_WAIT) ? m_cnt + 1 : 0;
            if (m_mode == M_DEC && pkt_valid) begin
                m_addr = a;
                m_sel  = (a < NCH) ? NCH'(1 << a) : '0;
            end
        end
        m_derr = (nx == M_DROP) && (m_mode != M_DROP);
        m_mode = nx;
    endtask

    task automatic compare();
        logic [8:0] obs;
        obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy, drop_state};
        chk("state_dec", 32'(obs), 32'(exp_bits(m_mode)));
        chk("sel_ch", 32'(sel_ch), 32'(m_sel));
        chk("drop_err", 32'(drop_err), 32'(m_derr));
        if (write_enb_reg) we_seen++;
    endtask

    task automatic cyc(input logic pv, input logic [AW-1:0] d,
                       input logic [NCH-1:0] emp, input logic ff,
                       input logic [NCH-1:0] sr, input logic pd,
                       input logic lpv);
        pkt_valid     = pv;
        data_in       = d;
        fifo_empty    = emp;
        fifo_full     = ff;
        soft_reset    = sr;
        parity_done   = pd;
        low_pkt_valid = lpv;
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        #1;
        compare();
        @(negedge clock);
        compare();
        resetn = 1'b1;
    endtask

    logic [NCH-1:0] emp_s;
    logic           full_s;

    initial begin
        resetn = 1'b0;
        pkt_valid = 1'b0;
        data_in = '0;
        fifo_empty = '1;
        fifo_full = 1'b0;
        soft_reset = '0;
        parity_done = 1'b0;
        low_pkt_valid = 1'b0;
        model_reset();
        @(negedge clock);
        do_reset();

        // Header to channel 3, four payload beats, parity.
        we_seen = 0;
        cyc(1, 3'd3, 4'b1000, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 3'd0, 4'b1000, 0, 0, 0, 0);
        cyc(0, 3'd0, 4'b1000, 0, 0, 0, 0);
        cyc(0, 3'd0, 4'b1000, 0, 0, 0, 0);
        cyc(0, 3'd0, 4'b1000, 0, 0, 0, 0);
        chk("we_cycles", 32'(we_seen), 32'd6);
        chk("sel_ch3", 32'(sel_ch), 32'h8);

        // Out-of-range header then reset while loading.
        cyc(1, 3'd5, 4'b1111, 0, 0, 0, 0);
        chk("drop_busy", 32'(busy), 32'd0);
        cyc(0, 3'd0, 4'b1111, 0, 0, 0, 0);
        cyc(1, 3'd1, 4'b0010, 0, 0, 0, 0);
        cyc(1, 3'd0, 4'b0010, 0, 0, 0, 0);
        do_reset();

        emp_s  = '1;
        full_s = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 9) == 0) emp_s = NCH'($urandom);
                if ($urandom_range(0, 4) == 0) full_s = ~full_s;
                cyc($urandom_range(0, 7) != 0,
                    AW'($urandom_range(0, 7)),
                    emp_s, full_s,
                    ($urandom_range(0, 39) == 0) ? NCH'($urandom) : '0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
